// File: rtl/lfsr_word_sequencer_pkg.sv
// Shared types and constants for the LFSR word sequencer.
// State encodings, seed width and the zero-seed substitute.
package lfsr_word_sequencer_pkg;

    localparam int SEED_W = 32;
    localparam logic [SEED_W-1:0] SEED_DEFAULT_C = 32'h0000_3039;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TAIL  = 3'd3,
        S_VALID = 3'd4
    } state_t;

    // An all-zero LFSR never leaves zero, so swap in a usable seed.
    function automatic logic [SEED_W-1:0] fix_seed(
        input logic [SEED_W-1:0] s,
        input logic [SEED_W-1:0] dflt
    );
        return (s == '0) ? dflt : s;
    endfunction

endpackage

// File: rtl/lfsr_word_sequencer_packer.sv
// Serial-to-parallel packer: captures Q one cycle after each shift.
// First captured bit ends up in the MSB.
module lfsr_bit_packer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word
);

    logic              pending;
    logic [WORD_W-1:0] next_word;

    generate
        if (WORD_W == 1) begin : g_one
            assign next_word = bit_in;
        end else begin : g_many
            assign next_word = {word[WORD_W-2:0], bit_in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            word    <= '0;
        end else if (clear) begin
            pending <= 1'b0;
            word    <= '0;
        end else begin
            pending <= shift;
            if (pending) word <= next_word;
        end
    end

endmodule

// File: rtl/lfsr_word_sequencer.sv
// Sequences a 32-bit LFSR: load seed, shift WORD_W bits per word,
// deliver words over valid/ready, pulse done after the last one.
module lfsr_word_sequencer
    import lfsr_word_sequencer_pkg::*;
#(
    parameter int          WORD_W       = 8,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       seed_in,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              lfsr_load_enable,
    output logic              lfsr_shift_enable,
    output logic [31:0]       lfsr_seed,
    input  logic              lfsr_q
);

    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [SEED_W-1:0]  seed_q;
    logic [CNT_W-1:0]   words_left;
    logic [BIT_W-1:0]   bit_cnt;
    logic               accept;
    logic               handshake;
    logic               last_word;
    logic               finish;

    assign accept    = (state == S_IDLE) && start && (num_words != '0);
    assign handshake = (state == S_VALID) && out_ready;
    assign last_word = (words_left <= CNT_W'(1));
    assign finish    = handshake && last_word && !abort;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (bit_cnt == LAST_BIT) state_nxt = S_TAIL;
            S_TAIL:  state_nxt = S_VALID;
            S_VALID: if (handshake) state_nxt = last_word ? S_IDLE : S_SHIFT;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            seed_q     <= '0;
            words_left <= '0;
            bit_cnt    <= '0;
            done       <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= finish;
            bit_cnt <= (state == S_SHIFT) ? bit_cnt + 1'b1 : '0;
            if (accept) begin
                seed_q     <= fix_seed(seed_in, SEED_DEFAULT);
                words_left <= num_words;
            end else if (handshake && !last_word && !abort) begin
                words_left <= words_left - 1'b1;
            end
        end
    end

    assign busy              = (state != S_IDLE);
    assign out_valid         = (state == S_VALID);
    assign lfsr_load_enable  = (state == S_LOAD);
    assign lfsr_shift_enable = (state == S_SHIFT);
    assign lfsr_seed         = seed_q;

    // Packer is held clear in IDLE so aborted partial words never leak out.
    lfsr_bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_IDLE),
        .shift  (lfsr_shift_enable),
        .bit_in (lfsr_q),
        .word   (out_data)
    );

endmodule

// File: tb/tb_lfsr_word_sequencer.sv
// Self-checking bench for lfsr_word_sequencer with a behavioural LFSR
// attached to its LFSR ports and a golden word generator.
module tb_lfsr_word_sequencer;

    localparam int W = 8;
    localparam logic [31:0] DEF_SEED = 32'h0000_3039;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed_in = '0;
    logic [15:0] num_words = '0;
    logic        abort = 1'b0;
    logic        busy, done, out_valid;
    logic [W-1:0] out_data;
    logic        out_ready = 1'b0;
    logic        lfsr_load_enable, lfsr_shift_enable;
    logic [31:0] lfsr_seed;
    logic        lfsr_q;

    int n_checks = 0;
    int n_fail = 0;
    int edges = 0;

    lfsr_word_sequencer #(.WORD_W(W), .CNT_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .seed_in           (seed_in),
        .num_words         (num_words),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .lfsr_load_enable  (lfsr_load_enable),
        .lfsr_shift_enable (lfsr_shift_enable),
        .lfsr_seed         (lfsr_seed),
        .lfsr_q            (lfsr_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    // Fibonacci LFSR, taps 32,22,2,1; Q is the MSB.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    logic [31:0] lfsr_state = '0;
    always @(posedge clk) begin
        if (lfsr_load_enable) lfsr_state <= lfsr_seed;
        else if (lfsr_shift_enable) lfsr_state <= lfsr_step(lfsr_state);
    end
    assign lfsr_q = lfsr_state[31];

    // Activity monitor, sampled mid-cycle.
    int mon_loads, mon_shifts, mon_dones, mon_overlap, mon_shift_valid;
    logic [31:0] mon_seed;
    always @(negedge clk) begin
        if (lfsr_load_enable) begin
            mon_loads++;
            mon_seed = lfsr_seed;
        end
        if (lfsr_shift_enable) mon_shifts++;
        if (done) mon_dones++;
        if (lfsr_load_enable && lfsr_shift_enable) mon_overlap++;
        if (lfsr_shift_enable && out_valid) mon_shift_valid++;
    end

    task automatic clear_mon();
        mon_loads = 0;
        mon_shifts = 0;
        mon_dones = 0;
        mon_overlap = 0;
        mon_shift_valid = 0;
        mon_seed = '0;
    endtask

    logic [W-1:0] gold [0:63];

    // Word k = bits k*W+1 .. k*W+W of the Q stream after loading s0.
    task automatic golden(input logic [31:0] s0, input int n);
        logic [31:0] s;
        logic [W-1:0] w;
        s = s0;
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int b = 0; b < W; b++) begin
                s = lfsr_step(s);
                w[W-1-b] = s[31];
            end
            gold[k] = w;
        end
    endtask

    task automatic issue_start(input logic [31:0] sd, input int n);
        @(negedge clk);
        start = 1'b1;
        seed_in = sd;
        num_words = 16'(n);
    endtask

    // hold: 0 = always ready, 1 = 5-cycle stall per word, 2 = random stall
    task automatic run_req(input string tag, input logic [31:0] sd,
                           input int n, input int hold);
        logic [31:0] eff;
        int e0, h_edge, waited, stall;
        logic [W-1:0] held;
        eff = (sd == 0) ? DEF_SEED : sd;
        golden(eff, n);
        clear_mon();
        out_ready = (hold == 0);
        issue_start(sd, n);
        @(posedge clk);
        #1;
        e0 = edges;
        h_edge = 0;
        start = 1'b0;
        for (int w = 0; w < n; w++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!out_valid && waited < 40);
            n_checks++;
            if (!out_valid) begin
                n_fail++;
                $display("FAIL %s timeout word %0d: out_valid=%b required 1",
                         tag, w, out_valid);
                return;
            end
            if (w == 0) begin
                n_checks++;
                if (edges - e0 !== W + 2) begin
                    n_fail++;
                    $display("FAIL %s first latency: got %0d required %0d",
                             tag, edges - e0, W + 2);
                end
            end else if (hold == 0) begin
                n_checks++;
                if (edges - h_edge !== W + 1) begin
                    n_fail++;
                    $display("FAIL %s word latency: got %0d required %0d",
                             tag, edges - h_edge, W + 1);
                end
            end
            n_checks++;
            if (out_data !== gold[w]) begin
                n_fail++;
                $display("FAIL %s word %0d: got %h required %h",
                         tag, w, out_data, gold[w]);
            end
            if (hold != 0) begin
                stall = (hold == 1) ? 5 : int'($urandom_range(0, 3));
                held = out_data;
                repeat (stall) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid !== 1'b1 || out_data !== held) begin
                        n_fail++;
                        $display("FAIL %s hold: valid=%b data=%h required 1/%h",
                                 tag, out_valid, out_data, held);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            h_edge = edges;
            if (hold != 0) out_ready = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done pulse: done=%b busy=%b required 1/0",
                     tag, done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done width: done=%b required 0", tag, done);
        end
        n_checks++;
        if (mon_loads !== 1 || mon_seed !== eff) begin
            n_fail++;
            $display("FAIL %s load: loads=%0d seed=%h required 1/%h",
                     tag, mon_loads, mon_seed, eff);
        end
        n_checks++;
        if (mon_shifts !== W * n) begin
            n_fail++;
            $display("FAIL %s shifts: got %0d required %0d",
                     tag, mon_shifts, W * n);
        end
        n_checks++;
        if (mon_dones !== 1 || mon_overlap !== 0 || mon_shift_valid !== 0) begin
            n_fail++;
            $display("FAIL %s misc: dones=%0d overlap=%0d shift_in_valid=%0d required 1/0/0",
                     tag, mon_dones, mon_overlap, mon_shift_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
            lfsr_load_enable !== 1'b0 || lfsr_shift_enable !== 1'b0 ||
            out_data !== '0 || lfsr_seed !== '0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b valid=%b ld=%b sh=%b data=%h seed=%h required all 0",
                     tag, busy, done, out_valid, lfsr_load_enable,
                     lfsr_shift_enable, out_data, lfsr_seed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");
    endtask

    task automatic test_basic();
        run_req("basic", 32'h3039, 3, 0);
    endtask

    task automatic test_backpressure();
        run_req("backpressure", 32'h3039, 3, 1);
    endtask

    task automatic test_zero_inputs();
        run_req("zero_seed", 32'h0, 2, 0);
        clear_mon();
        issue_start(32'h1234, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_count: busy=%b done=%b required 0/0",
                         busy, done);
            end
        end
        n_checks++;
        if (mon_loads !== 0) begin
            n_fail++;
            $display("FAIL zero_count loads: got %0d required 0", mon_loads);
        end
    endtask

    task automatic test_abort();
        logic [31:0] sd;
        int cnt, waited;
        sd = $urandom | 32'h1;
        golden(sd, 3);
        clear_mon();
        out_ready = 1'b1;
        issue_start(sd, 3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        seed_in = ~sd;
        num_words = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 40);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== gold[0]) begin
            n_fail++;
            $display("FAIL abort word0: valid=%b data=%h required 1/%h",
                     out_valid, out_data, gold[0]);
        end
        @(posedge clk);
        #1;
        cnt = 0;
        waited = 0;
        while (cnt < 4 && waited < 20) begin
            @(negedge clk);
            waited++;
            if (lfsr_shift_enable) cnt++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if (cnt !== 4 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort idle: shifts_seen=%0d busy=%b valid=%b required 4/0/0",
                     cnt, busy, out_valid);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (mon_dones !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort done: dones=%0d busy=%b required 0/0",
                     mon_dones, busy);
        end
        n_checks++;
        if (mon_loads !== 1 || mon_seed !== sd) begin
            n_fail++;
            $display("FAIL busy_start: loads=%0d seed=%h required 1/%h",
                     mon_loads, mon_seed, sd);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int waited;
        out_ready = 1'b0;
        issue_start($urandom | 32'h1, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 40);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid reach valid: valid=%b required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_req("after_reset_seed1", 32'h1, 3, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_req("random", $urandom, int'($urandom_range(1, 4)), 2);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_inputs();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
